// File: rtl/rv32i_packet_queue_pkg.sv
// Shared packet type and queue sizing for the rv32i pipeline queues.
package rv32i_packet;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } rv32i_packet_t;

   localparam int PKT_W       = $bits(rv32i_packet_t);
   localparam int PKT_Q_DEPTH = 4;

   typedef logic [$clog2(PKT_Q_DEPTH + 1) - 1:0] pkt_q_count_t;

endpackage

// File: rtl/rv32i_packet_queue_chk.sv
// Simulation-only protocol checks for rv32i_packet_queue.
module rv32i_packet_queue_chk
   import rv32i_packet::*;
#(
   parameter int WIDTH       = PKT_W,
   parameter int DEPTH       = 4,
   parameter int FALLTHROUGH = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic                       in_ready,
   input  logic [WIDTH-1:0]           in_pkt,
   input  logic                       out_valid,
   input  logic                       out_ready,
   input  logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int   CNT_W = $clog2(DEPTH + 1);
   localparam logic FT_C  = (FALLTHROUGH != 0);

   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      !(in_valid & in_ready & ~flush & (count == CNT_W'(DEPTH))));

   // an empty fall-through queue may pop only the bypassed input
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
      !(out_valid & out_ready & ~flush & (count == CNT_W'(0)) & ~(FT_C & in_valid)));

   a_in_pkt_stable: assert property (@(posedge clk) disable iff (rst)
      (in_valid & ~in_ready & ~flush) |=> (in_pkt == $past(in_pkt)));

endmodule

// File: rtl/rv32i_packet_queue_mem.sv
// Register-array storage for the packet queue; a drop-in point for an SRAM macro.
module rv32i_packet_queue_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // write port; contents are intentionally left unreset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/rv32i_packet_queue.sv
// Ready/valid packet FIFO with optional zero-latency fall-through and flush on redirect.
module rv32i_packet_queue
   import rv32i_packet::*;
#(
   parameter int WIDTH       = PKT_W,
   parameter int DEPTH       = 4,
   parameter int FALLTHROUGH = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_pkt,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_pkt,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int   PTR_W = $clog2(DEPTH);
   localparam int   CNT_W = $clog2(DEPTH + 1);
   localparam logic FT_C  = (FALLTHROUGH != 0);

   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [WIDTH-1:0] rd_data_s;
   logic             empty_s;
   logic             full_s;
   logic             push_s;
   logic             pop_s;
   logic             bypass_s;
   logic             wr_en_s;
   logic             rd_en_s;

   assign empty_s   = (count_r == CNT_W'(0));
   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign in_ready  = ~full_s;
   assign out_valid = ~empty_s | (FT_C & in_valid & ~flush);
   assign out_pkt   = (FT_C & empty_s) ? in_pkt : rd_data_s;
   assign count     = count_r;

   assign push_s   = in_valid & in_ready & ~flush;
   assign pop_s    = out_valid & out_ready & ~flush;
   // a fall-through packet consumed while empty never touches storage
   assign bypass_s = FT_C & empty_s & push_s & pop_s;
   assign wr_en_s  = push_s & ~bypass_s;
   assign rd_en_s  = pop_s & ~bypass_s;

   rv32i_packet_queue_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en_s),
      .wr_addr (wr_ptr_r),
      .wr_data (in_pkt),
      .rd_addr (rd_ptr_r),
      .rd_data (rd_data_s)
   );

   // pointer and occupancy update; reset outranks flush, flush outranks transfers
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_r <= PTR_W'(0);
         wr_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule
